event_packetizer: RTL and testbench
===================================

Name: event_packetizer

Overview:
- Sits directly downstream of the column arbiter.
- Captures each granted event as a row address (xadd), a column address (yadd) and a timestamp from a free-running counter.
- Packs each event into a word and buffers it in a small synchronous FIFO.
- Presents packets to the readout link with a valid/ready handshake, and tracks overflow and dropped events.

Parameters:
- Lvl_ROW_ADD, 1, width of the row address from the row arbiter.
- Lvl_COL_ADD, 1, width of the column address (the column arbiter's yadd_o).
- TS_WIDTH, 16, timestamp counter width.
- FIFO_DEPTH, 4, number of packet entries; must be a power of 2, ≥2.
- FIFO_ADD, 2, log2(FIFO_DEPTH).
- Derived localparam PKT_W = TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD.

Ports:
- clk_i  input  1  single clock; all state on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  block enable; gates the timestamp counter and event capture.
- evt_valid_i  input  1  high when the column grant is nonzero (the column arbiter's gnt_o reduced by OR).
- xadd_i  input  Lvl_ROW_ADD  granted row address.
- yadd_i  input  Lvl_COL_ADD  granted column address.
- pkt_ready_i  input  1  downstream accepts the packet.
- ovf_clr_i  input  1  single-cycle pulse; clears ovf_o and drop_cnt_o.
- pkt_valid_o  output  1  head-of-FIFO packet is valid.
- pkt_data_o  output  PKT_W  packet = {ts[TS_WIDTH-1:0], xadd, yadd}, timestamp in the MSBs.
- count_o  output  FIFO_ADD+1  current occupancy.
- full_o  output  1  count_o == FIFO_DEPTH.
- ts_wrap_o  output  1  one-cycle pulse when the timestamp wraps to 0.
- ovf_o  output  1  sticky flag: at least one event dropped.
- drop_cnt_o  output  8  saturating count of dropped events.

Behaviour:
- **Reset** (async, immediate):
  - Timestamp = 0, FIFO pointers = 0.
  - Outputs: count_o = 0, pkt_valid_o = 0, pkt_data_o = 0, full_o = 0, ts_wrap_o = 0, ovf_o = 0, drop_cnt_o = 0.
  - FIFO storage is not reset.
- **Timestamp counter:**
  - Increments by 1 each cycle while enable_i = 1; holds while enable_i = 0.
  - Wraps modulo 2^TS_WIDTH.
  - ts_wrap_o is registered: it is high in the cycle after the counter transitions from all-ones to 0.
- **Push condition:** push = enable_i & evt_valid_i.
  - The stored packet uses the counter value present in the push cycle (before that cycle's increment).
  - An event that is held across N cycles produces N packets. De-duplication is the arbiter's responsibility, since its grant changes every cycle.
- **Pop condition:** pop = pkt_valid_o & pkt_ready_i. Pop is independent of enable_i, so the FIFO drains while the block is disabled.
- **Latency:** a push in cycle N is visible on pkt_valid_o/pkt_data_o at cycle N+1 at the earliest. There is no combinational bypass from evt_valid_i to pkt_valid_o.
- **Output ordering and stability:**
  - pkt_data_o shows the head entry whenever pkt_valid_o = 1.
  - Order is strict FIFO.
  - pkt_data_o must stay stable while pkt_valid_o = 1 and pkt_ready_i = 0.
- **Full, no pop:** push is dropped.
  - ovf_o is set on the next edge.
  - drop_cnt_o increments, saturating at 255.
- **Full with simultaneous push and pop:** both succeed; count is unchanged and no drop occurs.
- **Empty with simultaneous push and pop:** cannot occur, because pkt_valid_o = 0 when empty.
- **Empty with push only:** count becomes 1 and pkt_valid_o = 1 next cycle.
- **ovf_clr_i:**
  - Clears ovf_o and drop_cnt_o on the next edge.
  - If a drop occurs in the same cycle, the drop wins: ovf_o = 1, drop_cnt_o = 1.
- **Pointer wrap:**
  - Read and write pointers are FIFO_ADD bits and wrap naturally.
  - Occupancy is tracked by a separate FIFO_ADD+1-bit counter.
  - full_o and pkt_valid_o are derived from the registered count.
- **enable_i falls mid-burst:** remaining buffered packets still drain; no new pushes are accepted; the timestamp freezes.

Test Plan:
- **Reset / idle:** assert reset_i mid-run with 2 entries buffered → all outputs 0 asynchronously; after release with enable_i = 1, the timestamp counts 0, 1, 2….
- **Single event:** enable at ts = 0, evt_valid_i = 1 at ts = 5 with xadd = 1, yadd = 0, pkt_ready_i = 1 → next cycle pkt_valid_o = 1, pkt_data_o = {16'd5, 1'b1, 1'b0}, held for one cycle.
- **Backpressure and overflow:** pkt_ready_i = 0, then 6 consecutive events →
  - count_o climbs 1–4 and full_o = 1;
  - the 5th and 6th events are dropped, giving ovf_o = 1 and drop_cnt_o = 2;
  - releasing ready → 4 packets in order with timestamps t, t+1, t+2, t+3.
- **Full with simultaneous push and pop:** FIFO full, pkt_ready_i = 1 and evt_valid_i = 1 together → count stays 4, drop_cnt_o is unchanged, and the new packet arrives last.
- **Timestamp wrap:** TS_WIDTH = 4, run 16 cycles → ts_wrap_o pulses once; an event captured at counter 15 and one at counter 0 carry ts 15 and 0 respectively.
- **Clear vs drop collision:** full FIFO with drop_cnt_o = 3; ovf_clr_i pulses in the same cycle as a dropped push → ovf_o = 1 and drop_cnt_o = 1. Also check saturation: after 300 drops, drop_cnt_o = 255.

Source files
------------

// File: rtl/event_packetizer.sv
// event_packetizer: timestamps each granted column-arbiter event, packs it as
// {ts, xadd, yadd} and queues it in a small FIFO for a valid/ready readout link.
// Events arriving while the FIFO is full are dropped and counted.
module event_packetizer #(
    parameter int Lvl_ROW_ADD = 1,
    parameter int Lvl_COL_ADD = 1,
    parameter int TS_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_ADD    = 2
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        enable_i,
    input  logic                                        evt_valid_i,
    input  logic [Lvl_ROW_ADD-1:0]                      xadd_i,
    input  logic [Lvl_COL_ADD-1:0]                      yadd_i,
    input  logic                                        pkt_ready_i,
    input  logic                                        ovf_clr_i,
    output logic                                        pkt_valid_o,
    output logic [TS_WIDTH+Lvl_ROW_ADD+Lvl_COL_ADD-1:0] pkt_data_o,
    output logic [FIFO_ADD:0]                           count_o,
    output logic                                        full_o,
    output logic                                        ts_wrap_o,
    output logic                                        ovf_o,
    output logic [7:0]                                  drop_cnt_o
);

    localparam int PKT_W = TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD;
    localparam logic [FIFO_ADD:0]   CNT_FULL = (FIFO_ADD + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_ADD:0]   CNT_ONE  = (FIFO_ADD + 1)'(1);
    localparam logic [FIFO_ADD-1:0] PTR_ONE  = FIFO_ADD'(1);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
    localparam logic [7:0]          DROP_MAX = 8'hFF;

    // Drop counter increments but never rolls over past all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                ts_wrap_q, ts_wrap_d;
    logic [FIFO_ADD-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADD-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADD:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [PKT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PKT_W-1:0]    mem_d;

    logic push, pop, full, wr_en, drop;

    // Handshake decode, timestamp, pointer/occupancy and overflow next-state.
    always_comb begin
        push  = enable_i & evt_valid_i;
        pop   = pkt_valid_o & pkt_ready_i;
        full  = (count_q == CNT_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        ts_d      = enable_i ? ts_q + TS_ONE : ts_q;
        ts_wrap_d = enable_i & (ts_q == '1);

        // Packet carries the counter value seen in the push cycle.
        mem_d = {ts_q, xadd_i, yadd_i};

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end

        // A drop coinciding with a clear restarts the count at one.
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = ovf_clr_i ? 8'd1 : sat_inc8(drop_cnt_q);
        end else if (ovf_clr_i) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q       <= '0;
            ts_wrap_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            ts_q       <= ts_d;
            ts_wrap_q  <= ts_wrap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Packet storage holds data only, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= mem_d;
        end
    end

    assign pkt_valid_o = (count_q != '0);
    assign full_o      = (count_q == CNT_FULL);
    assign count_o     = count_q;
    // Unreset storage is masked so the link sees zero whenever nothing is queued.
    assign pkt_data_o  = pkt_valid_o ? mem_q[rd_ptr_q] : '0;
    assign ts_wrap_o   = ts_wrap_q;
    assign ovf_o       = ovf_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Self-checking bench for event_packetizer: a vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_event_packetizer;

    localparam int TSW   = 16;
    localparam int TSW4  = 4;
    localparam int DEPTH = 4;
    localparam int PW    = TSW + 2;
    localparam int PW4   = TSW4 + 2;

    logic clk = 1'b0;
    logic rst, en, evt, x, y, rdy, clr;

    logic          pkt_valid, full, wrap, ovf;
    logic [PW-1:0] pkt_data;
    logic [2:0]    count;
    logic [7:0]    drop;

    logic           pkt_valid4, full4, wrap4, ovf4;
    logic [PW4-1:0] pkt_data4;
    logic [2:0]     count4;
    logic [7:0]     drop4;

    always #5 clk = ~clk;

    event_packetizer #(.Lvl_ROW_ADD(1), .Lvl_COL_ADD(1), .TS_WIDTH(TSW),
                       .FIFO_DEPTH(DEPTH), .FIFO_ADD(2)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .evt_valid_i(evt),
        .xadd_i(x), .yadd_i(y), .pkt_ready_i(rdy), .ovf_clr_i(clr),
        .pkt_valid_o(pkt_valid), .pkt_data_o(pkt_data), .count_o(count),
        .full_o(full), .ts_wrap_o(wrap), .ovf_o(ovf), .drop_cnt_o(drop)
    );

    event_packetizer #(.Lvl_ROW_ADD(1), .Lvl_COL_ADD(1), .TS_WIDTH(TSW4),
                       .FIFO_DEPTH(DEPTH), .FIFO_ADD(2)) dut4 (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .evt_valid_i(evt),
        .xadd_i(x), .yadd_i(y), .pkt_ready_i(rdy), .ovf_clr_i(clr),
        .pkt_valid_o(pkt_valid4), .pkt_data_o(pkt_data4), .count_o(count4),
        .full_o(full4), .ts_wrap_o(wrap4), .ovf_o(ovf4), .drop_cnt_o(drop4)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int            m_ts;
    logic [PW-1:0] m_q[$];
    int            m_drop;
    bit            m_ovf, m_wrap, m_wrap4;

    typedef struct {
        logic [5:0] stim;   // {en, evt, x, y, rdy, clr}
        int ev, ec, ef, eo, ed, edat;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] s, input int v, input int c,
                                input int f, input int o, input int d, input int dat);
        vec_t r;
        r.stim = s; r.ev = v; r.ec = c; r.ef = f; r.eo = o; r.ed = d; r.edat = dat;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        m_ts = 0; m_q.delete(); m_drop = 0; m_ovf = 0; m_wrap = 0; m_wrap4 = 0;
    endfunction

    // Advances the model by one clock using the inputs about to be sampled.
    function automatic void model_update();
        bit do_pop, do_push, do_drop;
        do_pop  = (m_q.size() > 0) && rdy;
        do_push = en && evt;
        do_drop = do_push && (m_q.size() == DEPTH) && !do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (do_push && !do_drop) m_q.push_back({m_ts[TSW-1:0], x, y});
        if (do_drop) begin
            m_ovf  = 1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ovf = 0; m_drop = 0;
        end
        m_wrap  = en && (m_ts == 65535);
        m_wrap4 = en && ((m_ts % 16) == 15);
        if (en) m_ts = (m_ts + 1) % 65536;
    endfunction

    task automatic model_check(input string tag);
        logic [PW-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        check({tag, " valid"},  longint'(pkt_valid),  longint'(m_q.size() > 0));
        check({tag, " count"},  longint'(count),      longint'(m_q.size()));
        check({tag, " full"},   longint'(full),       longint'(m_q.size() == DEPTH));
        check({tag, " data"},   longint'(pkt_data),   longint'(head));
        check({tag, " ovf"},    longint'(ovf),        longint'(m_ovf));
        check({tag, " drop"},   longint'(drop),       longint'(m_drop));
        check({tag, " wrap"},   longint'(wrap),       longint'(m_wrap));
        check({tag, " wrap4"},  longint'(wrap4),      longint'(m_wrap4));
        check({tag, " valid4"}, longint'(pkt_valid4), longint'(m_q.size() > 0));
        check({tag, " count4"}, longint'(count4),     longint'(m_q.size()));
        check({tag, " full4"},  longint'(full4),      longint'(m_q.size() == DEPTH));
        check({tag, " ovf4"},   longint'(ovf4),       longint'(m_ovf));
        check({tag, " drop4"},  longint'(drop4),      longint'(m_drop));
    endtask

    task automatic step(input logic e, input logic v, input logic xa, input logic ya,
                        input logic r, input logic c);
        en = e; evt = v; x = xa; y = ya; rdy = r; clr = c;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 0; evt = 0; x = 0; y = 0; rdy = 0; clr = 0; rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        int t0, pulses;
        logic [PW-1:0] exp_d;

        rst = 1; en = 0; evt = 0; x = 0; y = 0; rdy = 0; clr = 0;
        do_reset();
        model_check("reset");

        // Single event, backpressure/overflow, clear, enable gating
        for (int i = 0; i < 5; i++) tbl.push_back(mk(6'b100010, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b111010, 1, 1, 0, 0, 0, 22));
        tbl.push_back(mk(6'b100010, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b110100, 1, 1, 0, 0, 0, 29));
        tbl.push_back(mk(6'b111100, 1, 2, 0, 0, 0, 29));
        tbl.push_back(mk(6'b111100, 1, 3, 0, 0, 0, 29));
        tbl.push_back(mk(6'b111100, 1, 4, 1, 0, 0, 29));
        tbl.push_back(mk(6'b110000, 1, 4, 1, 1, 1, 29));
        tbl.push_back(mk(6'b110000, 1, 4, 1, 1, 2, 29));
        tbl.push_back(mk(6'b100010, 1, 3, 0, 1, 2, 35));
        tbl.push_back(mk(6'b100010, 1, 2, 0, 1, 2, 39));
        tbl.push_back(mk(6'b100010, 1, 1, 0, 1, 2, 43));
        tbl.push_back(mk(6'b100010, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(6'b100011, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b010000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'b110000, 1, 1, 0, 0, 0, 72));
        tbl.push_back(mk(6'b010010, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].stim[5], tbl[i].stim[4], tbl[i].stim[3],
                 tbl[i].stim[2], tbl[i].stim[1], tbl[i].stim[0]);
            check($sformatf("tbl%0d valid", i), longint'(pkt_valid), longint'(tbl[i].ev));
            check($sformatf("tbl%0d count", i), longint'(count),     longint'(tbl[i].ec));
            check($sformatf("tbl%0d full", i),  longint'(full),      longint'(tbl[i].ef));
            check($sformatf("tbl%0d ovf", i),   longint'(ovf),       longint'(tbl[i].eo));
            check($sformatf("tbl%0d drop", i),  longint'(drop),      longint'(tbl[i].ed));
            check($sformatf("tbl%0d data", i),  longint'(pkt_data),  longint'(tbl[i].edat));
        end

        // Full FIFO with simultaneous push and pop
        t0 = m_ts;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
        check("fill count", longint'(count), 4);
        check("fill full",  longint'(full), 1);
        step(1, 1, 1, 1, 1, 0);
        check("pp count", longint'(count), 4);
        check("pp drop",  longint'(drop), 0);
        exp_d = {TSW'(t0 + 1), 2'b00};
        check("pp head", longint'(pkt_data), longint'(exp_d));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        exp_d = {TSW'(t0 + 4), 2'b11};
        check("pp last", longint'(pkt_data), longint'(exp_d));
        check("pp last count", longint'(count), 1);
        step(1, 0, 0, 0, 1, 0);
        model_check("pp drained");

        // Clear colliding with a drop, then saturation
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 0);
        check("drop3", longint'(drop), 3);
        step(1, 1, 0, 0, 0, 1);
        check("clrdrop ovf",  longint'(ovf), 1);
        check("clrdrop drop", longint'(drop), 1);
        for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 0, 0);
        check("sat drop", longint'(drop), 255);
        check("sat ovf",  longint'(ovf), 1);
        model_check("sat");

        // Asynchronous reset with two entries buffered
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        check("pre-rst count", longint'(count), 2);
        #2;
        rst = 1;
        #1;
        check("arst valid", longint'(pkt_valid), 0);
        check("arst data",  longint'(pkt_data), 0);
        check("arst count", longint'(count), 0);
        check("arst full",  longint'(full), 0);
        check("arst wrap",  longint'(wrap), 0);
        check("arst ovf",   longint'(ovf), 0);
        check("arst drop",  longint'(drop), 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0);
        check("ts0 head", longint'(pkt_data), 1);
        step(0, 0, 0, 0, 1, 0);
        check("ts1 head", longint'(pkt_data), 5);
        step(0, 0, 0, 0, 1, 0);
        check("ts2 head", longint'(pkt_data), 9);
        step(0, 0, 0, 0, 1, 0);
        model_check("ts drained");

        // Timestamp wrap on the 4-bit instance
        do_reset();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0, 1, 0);
            pulses += int'(wrap4);
        end
        step(1, 1, 1, 1, 1, 0);
        pulses += int'(wrap4);
        check("wrap4 pulse", longint'(wrap4), 1);
        check("ts15 data4",  longint'(pkt_data4), 63);
        step(1, 1, 1, 0, 1, 0);
        pulses += int'(wrap4);
        check("ts0 data4",   longint'(pkt_data4), 2);
        check("ts0 valid4",  longint'(pkt_valid4), 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 1, 0);
            pulses += int'(wrap4);
        end
        check("wrap4 pulses", longint'(pulses), 1);
        model_check("wrap done");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(9) < 8), 1'($urandom_range(9) < 6),
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(9) < 4), 1'($urandom_range(19) == 0));
            model_check($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
